// File: rtl/gcdlcm_n.sv
// gcd/lcm unit for W-bit unsigned operands: binary GCD, then optional divide + shift-add multiply for lcm.
// Define GCDLCM_LCM_EN to build the divider/multiplier and honour mode; otherwise every request computes gcd.
module gcdlcm_n #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode,
    input  logic [W-1:0]   ina,
    input  logic [W-1:0]   inb,
    output logic [2*W-1:0] result,
    output logic           ready_n,
    output logic           busy,
    output logic           err
);

    localparam int KW = $clog2(W);

    typedef enum logic [2:0] {
        IDLE, ALIGN, ODD, REDUCE, DONE
`ifdef GCDLCM_LCM_EN
        , DIV, MUL
`endif
    } state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  a_reg, a_next;
    logic [W-1:0]  b_reg, b_next;
    logic [W-1:0]  a0_reg, a0_next;
    logic [W-1:0]  b0_reg, b0_next;
    logic [W-1:0]  g_reg, g_next;
    logic [KW-1:0] k_reg, k_next;
    logic          err_reg, err_next;
    logic          ready_n_reg, ready_n_next;
    logic          busy_reg, busy_next;
    logic [W:0]    diff;
    logic          accept;

`ifdef GCDLCM_LCM_EN
    logic [2*W-1:0] result_reg, result_next;
    logic           mode_reg, mode_next;
    logic [W-1:0]   rem_reg, rem_next;
    logic [W-1:0]   q_reg, q_next;
    logic [2*W-1:0] acc_reg, acc_next;
    logic [2*W-1:0] mcand_reg, mcand_next;
    logic [KW-1:0]  cnt_reg, cnt_next;
    logic [W:0]     rem_sh;
    logic           rem_ge;
    logic [W-1:0]   rem_sub;

    assign result  = result_reg;
    assign rem_sh  = {rem_reg, q_reg[W-1]};
    assign rem_ge  = (rem_sh >= {1'b0, g_reg});
    // When rem_sh >= g the difference is below g, so W bits hold it.
    assign rem_sub = rem_sh[W-1:0] - g_reg;
`else
    logic [W-1:0] result_reg, result_next;
    logic         unused_mode;

    assign result      = {{W{1'b0}}, result_reg};
    assign unused_mode = mode;
`endif

    assign ready_n = ready_n_reg;
    assign busy    = busy_reg;
    assign err     = err_reg;

    // W+1 bit subtract: the top bit is the a<b flag.
    assign diff   = {1'b0, a_reg} - {1'b0, b_reg};
    assign accept = start && !busy_reg && (state_reg == IDLE || state_reg == DONE);

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        a0_next      = a0_reg;
        b0_next      = b0_reg;
        g_next       = g_reg;
        k_next       = k_reg;
        err_next     = err_reg;
        ready_n_next = ready_n_reg;
        busy_next    = busy_reg;
        result_next  = result_reg;
`ifdef GCDLCM_LCM_EN
        mode_next    = mode_reg;
        rem_next     = rem_reg;
        q_next       = q_reg;
        acc_next     = acc_reg;
        mcand_next   = mcand_reg;
        cnt_next     = cnt_reg;
`endif

        case (state_reg)
            ALIGN: begin
                if (!a_reg[0] && !b_reg[0]) begin
                    a_next = a_reg >> 1;
                    b_next = b_reg >> 1;
                    k_next = k_reg + KW'(1);
                end else begin
                    state_next = ODD;
                end
            end
            ODD: begin
                if (!a_reg[0]) a_next = a_reg >> 1;
                else           state_next = REDUCE;
            end
            REDUCE: begin
                if (b_reg == '0) begin
                    g_next = a_reg << k_reg;
`ifdef GCDLCM_LCM_EN
                    if (mode_reg) begin
                        state_next = DIV;
                        rem_next   = '0;
                        q_next     = a0_reg;
                        cnt_next   = '0;
                    end else begin
                        state_next = DONE;
                    end
`else
                    state_next = DONE;
`endif
                end else if (!b_reg[0]) begin
                    b_next = b_reg >> 1;
                end else if (diff[W]) begin
                    b_next = b_reg - a_reg;
                end else begin
                    a_next = b_reg;
                    b_next = diff[W-1:0];
                end
            end
`ifdef GCDLCM_LCM_EN
            DIV: begin
                // q_reg doubles as the dividend shift register; quotient bits enter at the bottom.
                rem_next = rem_ge ? rem_sub : rem_sh[W-1:0];
                q_next   = {q_reg[W-2:0], rem_ge};
                cnt_next = cnt_reg + KW'(1);
                if (cnt_reg == KW'(W - 1)) begin
                    state_next = MUL;
                    cnt_next   = '0;
                    acc_next   = '0;
                    mcand_next = {{W{1'b0}}, b0_reg};
                end
            end
            MUL: begin
                if (q_reg[0]) acc_next = acc_reg + mcand_reg;
                mcand_next = mcand_reg << 1;
                q_next     = q_reg >> 1;
                cnt_next   = cnt_reg + KW'(1);
                if (cnt_reg == KW'(W - 1)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end
            end
`endif
            DONE: begin
                // busy still high means this is the first DONE cycle: publish the result.
                if (busy_reg) begin
                    busy_next    = 1'b0;
                    ready_n_next = 1'b0;
`ifdef GCDLCM_LCM_EN
                    if (err_reg)
                        result_next = mode_reg ? '0 : {{W{1'b0}}, a0_reg | b0_reg};
                    else
                        result_next = mode_reg ? acc_reg : {{W{1'b0}}, g_reg};
`else
                    result_next = err_reg ? (a0_reg | b0_reg) : g_reg;
`endif
                end
            end
            default: ;
        endcase

        if (accept) begin
            a0_next      = ina;
            b0_next      = inb;
            a_next       = ina;
            b_next       = inb;
            k_next       = '0;
            ready_n_next = 1'b1;
            busy_next    = 1'b1;
`ifdef GCDLCM_LCM_EN
            mode_next    = mode;
            cnt_next     = '0;
`endif
            if (ina == '0 || inb == '0) begin
                err_next   = 1'b1;
                state_next = DONE;
            end else begin
                err_next   = 1'b0;
                state_next = ALIGN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            a0_reg      <= '0;
            b0_reg      <= '0;
            g_reg       <= '0;
            k_reg       <= '0;
            err_reg     <= 1'b0;
            ready_n_reg <= 1'b1;
            busy_reg    <= 1'b0;
            result_reg  <= '0;
`ifdef GCDLCM_LCM_EN
            mode_reg    <= 1'b0;
            rem_reg     <= '0;
            q_reg       <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            cnt_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            a0_reg      <= a0_next;
            b0_reg      <= b0_next;
            g_reg       <= g_next;
            k_reg       <= k_next;
            err_reg     <= err_next;
            ready_n_reg <= ready_n_next;
            busy_reg    <= busy_next;
            result_reg  <= result_next;
`ifdef GCDLCM_LCM_EN
            mode_reg    <= mode_next;
            rem_reg     <= rem_next;
            q_reg       <= q_next;
            acc_reg     <= acc_next;
            mcand_reg   <= mcand_next;
            cnt_reg     <= cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_gcdlcm_n.sv
// Scoreboard bench for gcdlcm_n: driver pushes expected results, monitor checks on each ready_n fall.
module tb_gcdlcm_n;
    localparam int W = 32;
`ifdef GCDLCM_LCM_EN
    localparam bit LCM = 1'b1;
`else
    localparam bit LCM = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic [W-1:0]   ina = '0;
    logic [W-1:0]   inb = '0;
    logic [2*W-1:0] result;
    logic           ready_n;
    logic           busy;
    logic           err;

    always #5 clk = ~clk;

    gcdlcm_n #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .ina(ina), .inb(inb), .result(result), .ready_n(ready_n),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic [2*W-1:0] exp_res;
        logic           exp_err;
        int             e0;
        bit             zero;
        bit             is_lcm;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   last_lat = 0;
    logic prev_rn = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [2*W-1:0] ref_lcm(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] g;
        if (x == 0 || y == 0) return '0;
        g = ref_gcd(x, y);
        return (2*W)'(x / g) * (2*W)'(y);
    endfunction

    task automatic check(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, expv);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input bit push);
        exp_t e;
        @(negedge clk);
        ina = a; inb = b; mode = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {{(2*W-1){1'b0}}, busy}, 1);
        check("ready_n_after_start", {{(2*W-1){1'b0}}, ready_n}, 1);
        if (push) begin
            e.a = a;
            e.b = b;
            e.is_lcm = LCM && m;
            e.zero = (a == 0 || b == 0);
            e.exp_err = e.zero;
            e.exp_res = e.is_lcm ? ref_lcm(a, b) : {{W{1'b0}}, ref_gcd(a, b)};
            e.e0 = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && !ready_n) begin
                #1;
                return;
            end
        end
        n_vec++;
        n_miss++;
        $display("FAIL timeout: got no result within 2000 cycles, required completion");
    endtask

    // Monitor: one scoreboard pop per falling edge of ready_n.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        int   bound;
        if (prev_rn && !ready_n) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result: got 0x%0h, required no result", result);
            end else begin
                e = sbq.pop_front();
                lat = cyc - e.e0 + 1;
                last_lat = lat;
                $display("txn a=0x%0h b=0x%0h lcm=%0b result=0x%0h err=%0b lat=%0d",
                         e.a, e.b, e.is_lcm, result, err, lat);
                check("result", result, e.exp_res);
                check("err", {{(2*W-1){1'b0}}, err}, {{(2*W-1){1'b0}}, e.exp_err});
                if (e.zero) begin
                    check("latency_zero", (2*W)'(lat), 2);
                end else begin
                    bound = e.is_lcm ? 6*W + 6 : 4*W + 6;
                    n_vec++;
                    if (lat < 5 || lat > bound) begin
                        n_miss++;
                        $display("FAIL latency: got %0d, required 5..%0d", lat, bound);
                    end
                end
            end
        end
        prev_rn = ready_n;
    end

    initial begin
        int           lat_lcm;
        int           lat_gcd;
        int           sel;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 0);
        check("reset_ready_n", {{(2*W-1){1'b0}}, ready_n}, 1);
        check("reset_busy", {{(2*W-1){1'b0}}, busy}, 0);
        check("reset_err", {{(2*W-1){1'b0}}, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'd640, 32'd120, 1'b1, 1'b1); wait_done(); lat_lcm = last_lat;
        issue(32'd640, 32'd120, 1'b0, 1'b1); wait_done(); lat_gcd = last_lat;
        check("lcm_minus_gcd_latency", (2*W)'(lat_lcm - lat_gcd), LCM ? 2*W : 0);

        issue(32'd2502, 32'd122, 1'b1, 1'b1); wait_done();
        issue(32'd1402, 32'd291, 1'b1, 1'b1); wait_done();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b1); wait_done();
        issue(32'h8000_0000, 32'h4000_0000, 1'b0, 1'b1); wait_done();
        issue(32'd0, 32'd77, 1'b0, 1'b1); wait_done();
        issue(32'd0, 32'd0, 1'b0, 1'b1); wait_done();
        issue(32'd0, 32'd77, 1'b1, 1'b1); wait_done();
        issue(32'd255, 32'd255, 1'b1, 1'b1); wait_done();
        issue(32'd254, 32'd127, 1'b1, 1'b1); wait_done();

        // A start while busy must be ignored.
        issue(32'd3000, 32'd1250, 1'b1, 1'b1);
        @(negedge clk);
        ina = 32'd7; inb = 32'd5; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Asynchronous reset in the middle of an operation.
        issue(32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_result", result, 0);
        check("midreset_ready_n", {{(2*W-1){1'b0}}, ready_n}, 1);
        check("midreset_busy", {{(2*W-1){1'b0}}, busy}, 0);
        check("midreset_err", {{(2*W-1){1'b0}}, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd12, 32'd18, 1'b1, 1'b1); wait_done();

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom_range(1, 1000); rb = $urandom_range(1, 1000); end
                2: begin
                    ra = W'($urandom_range(1, 4095)) << $urandom_range(0, 20);
                    rb = W'($urandom_range(1, 4095)) << $urandom_range(0, 20);
                end
                default: begin
                    ra = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom_range(1, 5000));
                    rb = ($urandom_range(0, 1) == 0) ? '0 : $urandom;
                end
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
            wait_done();
        end

        repeat (4) @(negedge clk);
        check("scoreboard_pending", (2*W)'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/gcdlcm_n.md
# gcdlcm_n

Parametrised successor to the fixed 32-bit GCD/LCM units in the RSA datapath. It computes gcd(a,b) or lcm(a,b) for W-bit unsigned operands:
- GCD uses a binary (Stein) iteration.
- LCM is formed as (a/g)*b, using a sequential divider followed by a shift-add multiplier.

An explicit start/busy handshake replaces reset-as-start, and the result stays valid until the next request.

## Interface
Parameters:
- W, 32, operand width in bits, W >= 4

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request pulse; sampled only when busy=0
- mode  in  1  0 = gcd, 1 = lcm; latched with start
- ina  in  W  operand a; latched with start
- inb  in  W  operand b; latched with start
- result  out  2W  gcd zero-extended, or full lcm
- ready_n  out  1  active-low result valid
- busy  out  1  operation in progress
- err  out  1  at least one operand was zero

## Operation
States: IDLE, ALIGN, ODD, REDUCE, DIV, MUL, DONE.

- **IDLE/DONE, start=1:**
  - Latch ina, inb and mode.
  - Drive ready_n=1, busy=1, k=0.
  - If either operand is zero, go to DONE directly. gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0, lcm(0,x)=0. err=1.
  - Otherwise err=0 and go to ALIGN.
- **ALIGN:** while a and b are both even, shift both right by 1 and increment k, one shift per cycle. Otherwise go to ODD.
- **ODD:** while a is even, shift a right by 1. Otherwise go to REDUCE.
- **REDUCE:** one action per cycle, with a held odd:
  - b==0: g = a<<k, then go to DIV (mode=1) or DONE (mode=0).
  - b even: b >>= 1.
  - else: a' = min(a,b), b' = |a-b|.
- **DIV:** exactly W restoring-division cycles give q = a0/g, where a0 is the latched ina. The remainder is always 0.
- **MUL:** exactly W shift-add cycles give result = q*b0, where b0 is the latched inb. The 2W-bit accumulator cannot overflow because lcm < 2^(2W).
- **DONE:** result registered; ready_n=0, busy=0. Hold result, err and ready_n until the next accepted start.

Rules:
- start while busy=1 is ignored, and latched operands are not disturbed.
- In gcd mode, result[2W-1:W] = 0.
- All arithmetic is unsigned. The subtractor is W+1 bits wide to give the compare.

## Timing
- **Reset (asynchronous, any state, including mid-operation):**
  - State = IDLE.
  - result=0, ready_n=1, busy=0, err=0.
  - All internal registers are cleared.
  - The first start is accepted on the first rising edge after rst_n rises.
- start accepted at edge E0: busy=1 and ready_n=1 are visible after E0.
- **Zero operand:** DONE is entered at E0. ready_n=0 and busy=0 after E0+1.
- **Nonzero, gcd mode:** ready_n=0 after E0+1+Na+No+Nr, where Na, No and Nr are the cycles spent in ALIGN, ODD and REDUCE (each ≥ 1). The worst case is bounded by 4W+4 cycles.
- **lcm mode:** exactly 2W cycles more than gcd mode for the same operands.
- A start in DONE is accepted on the same edge; ready_n returns to 1 after that edge.
- Outputs are registered; no combinational path runs from inputs to outputs.

## Configuration
- **GCDLCM_LCM_EN defined:** DIV and MUL states, the divider and the multiplier are built, and mode is honoured.
- **GCDLCM_LCM_EN undefined:**
  - DIV and MUL and their datapath are absent.
  - mode is ignored and every request computes gcd.
  - lcm zero-operand handling is replaced by the gcd zero rule.
  - result[2W-1:W] is tied to 0.
  - The port list is unchanged.

## Test plan
- W=32, lcm: 640,120 -> result 1920, err=0. Same operands in gcd mode -> 40, with latency exactly 64 cycles shorter.
- W=32, lcm, back-to-back with start asserted in DONE: 2502,122 -> 152622; then 1402,291 -> 407982. ready_n deasserts between the two requests.
- W=32, lcm: 0xFFFFFFFF,0xFFFFFFFE -> 0xFFFFFFFD00000002. gcd mode: 0x80000000,0x40000000 -> 0x40000000; the ALIGN count of 30 is checked in the waveform.
- Zero operands, gcd mode: 0,77 -> 77; 0,0 -> 0. Zero operands, lcm mode: 0,77 -> 0. All three give err=1 with ready_n low 2 edges after start.
- W=8 instance, lcm: 255,255 -> 255; 254,127 -> 254. start pulsed while busy is ignored and the result is unchanged.
- rst_n pulsed low mid-REDUCE: all outputs go to reset values immediately. A new request 12,18 then gives lcm 36 correctly.
